// File: rtl/pulse_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_rr_scheduler_if
// Description : Request/grant/pulse bundle between requesters and scheduler.
// Revision    : 1.0
// ============================================================================
interface pulse_rr_scheduler_if #(
    parameter int N = 4
);
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic         L;
    logic         busy;
    logic         tick;

    modport master (output req, input grant, input done, input L, input busy, input tick);
    modport slave  (input req, output grant, output done, output L, output busy, output tick);
endinterface
`default_nettype wire

// File: rtl/pulse_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pulse_rr_scheduler
// Description : Round-robin owner of one shared pulse line, sampled on ticks.
// Revision    : 1.0
// ============================================================================
module pulse_rr_scheduler #(
    parameter int N         = 4,
    parameter int DIV       = 2,
    parameter int PULSE_LEN = 1,
    parameter int GAP_LEN   = 1
) (
    input  wire logic           CLK,
    input  wire logic           reset,
    pulse_rr_scheduler_if.slave bus
);

    localparam int c_PTR_W  = (N > 1) ? $clog2(N) : 1;
    localparam int c_DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_PH_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int c_PH_W   = $clog2(c_PH_MAX + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(DIV - 1);
    localparam logic [c_PH_W-1:0]  c_PULSE_LAST = c_PH_W'(PULSE_LEN - 1);
    localparam logic [c_PH_W-1:0]  c_GAP_LAST   = c_PH_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [c_PTR_W-1:0] c_PTR_INIT   = c_PTR_W'(N - 1);
    localparam logic [N-1:0]       c_ONE        = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_DIV_W-1:0]   div_q, div_d;
    logic                 tick_q, tick_d;
    logic [c_PH_W-1:0]    ph_q, ph_d;
    logic [c_PTR_W-1:0]   ptr_q, ptr_d;
    logic [N-1:0]         grant_q, grant_d;
    logic [N-1:0]         done_q, done_d;
    logic                 l_q, l_d;
    logic                 busy_q, busy_d;

    logic                 w_found;
    logic [c_PTR_W-1:0]   w_win;

    // First requester strictly after the last winner, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = ptr_q;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && bus.req[c_PTR_W'((int'(ptr_q) + k) % N)]) begin
                w_found = 1'b1;
                w_win   = c_PTR_W'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = (div_q == c_DIV_LAST) ? '0 : div_q + 1'b1;
        tick_d  = (div_q == c_DIV_LAST);
        ph_d    = ph_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        done_d  = '0;
        l_d     = l_q;
        case (state_q)
            S_IDLE: begin
                if (tick_q && w_found) begin
                    state_d = S_PULSE;
                    grant_d = c_ONE << w_win;
                    l_d     = 1'b1;
                    ptr_d   = w_win;
                    ph_d    = '0;
                end
            end
            S_PULSE: begin
                if (ph_q == c_PULSE_LAST) begin
                    grant_d = '0;
                    l_d     = 1'b0;
                    done_d  = grant_q;
                    ph_d    = '0;
                    state_d = (GAP_LEN > 0) ? S_GAP : S_IDLE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_GAP: begin
                if (ph_q == c_GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            tick_q  <= 1'b0;
            ph_q    <= '0;
            ptr_q   <= c_PTR_INIT;
            grant_q <= '0;
            done_q  <= '0;
            l_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            ph_q    <= ph_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            l_q     <= l_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.L     = l_q;
    assign bus.busy  = busy_q;
    assign bus.tick  = tick_q;

endmodule
`default_nettype wire
